pressure_scan_scheduler: RTL and testbench

Round-robin scheduler that shares one combinational `pressureAbnormalityDetector` instance among `NUM_CH` pressure-sensor requesters. Each accepted sample goes through the detector, the result is registered, and a per-channel run of consecutive abnormal samples is tracked. An alarm is raised when that run reaches a threshold. Sits between the sensor front-ends and the system alarm and controller logic.

---
 rtl/pressure_pkg.sv | 11 +
 rtl/pressureAbnormalityDetector.sv | 10 +
 rtl/pressure_scan_scheduler_rr_pick.sv | 29 ++
 rtl/pressure_scan_scheduler.sv | 131 +++++++++++++
 tb/tb_pressure_scan_scheduler.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pressure_pkg.sv
// Shared types and constants for the pressure scan scheduler.
package pressure_pkg;
  localparam int unsigned PRESSURE_W     = 6;
  localparam int unsigned THRESH_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    EVAL   = 2'd2
  } state_t;
endpackage

// File: rtl/pressureAbnormalityDetector.sv
// Combinational pressure checker: flags samples outside the normal band [8, 55].
module pressureAbnormalityDetector
  import pressure_pkg::*;
(
  input  logic [PRESSURE_W-1:0] pressureData,
  output logic                  pressureAbnormality
);
  assign pressureAbnormality = (pressureData < PRESSURE_W'(8)) ||
                               (pressureData > PRESSURE_W'(55));
endmodule

// File: rtl/pressure_scan_scheduler_rr_pick.sv
// Round-robin picker: first requester at or above ptr, wrapping, as a one-hot grant.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic [PW:0]   sum;
  logic [PW-1:0] sel;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    sel   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      sel = sum[PW-1:0];
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pressure_scan_scheduler.sv
// Shares one abnormality detector among NUM_CH requesters and tracks per-channel
// abnormal runs. PRESSURE_ALARM_STICKY_EN makes alarms latch until alarmClr.
module pressure_scan_scheduler
  import pressure_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned THRESH = THRESH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH*PRESSURE_W-1:0] reqData,
  output logic [NUM_CH-1:0]            grant,
  output logic                         resValid,
  output logic [$clog2(NUM_CH)-1:0]    resCh,
  output logic                         resAbn,
  output logic [NUM_CH-1:0]            alarm,
  input  logic [NUM_CH-1:0]            alarmClr,
  output logic                         busy
);
  localparam int unsigned CHW = $clog2(NUM_CH);
  localparam int unsigned CW  = $clog2(THRESH + 1);

  state_t                state, state_nxt;
  logic [NUM_CH-1:0]     pick;
  logic [CHW-1:0]        rr_ptr, ch_reg, pick_ch;
  logic [PRESSURE_W-1:0] smp_reg, pick_smp;
  logic                  abn_reg, det_abn;
  logic [CW-1:0]         cnt     [NUM_CH];
  logic [CW-1:0]         cnt_nxt [NUM_CH];
  logic [CW-1:0]         cnt_upd;
  logic [NUM_CH-1:0]     eval_hit;

  rr_pick #(.N(NUM_CH), .PW(CHW)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (pick)
  );

  pressureAbnormalityDetector u_det (
    .pressureData        (smp_reg),
    .pressureAbnormality (det_abn)
  );

  always_comb begin
    pick_ch  = '0;
    pick_smp = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (pick[i]) begin
        pick_ch  = CHW'(i);
        pick_smp = reqData[i*PRESSURE_W +: PRESSURE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = '0;
    resValid  = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          grant     = pick;
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        busy      = 1'b1;
        state_nxt = EVAL;
      end
      EVAL: begin
        busy      = 1'b1;
        resValid  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign resCh  = ch_reg;
  assign resAbn = abn_reg;

  always_comb begin
    cnt_upd = '0;
    if (abn_reg)
      cnt_upd = (cnt[ch_reg] == CW'(THRESH)) ? CW'(THRESH) : cnt[ch_reg] + 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      eval_hit[i] = (state == EVAL) && (ch_reg == CHW'(i));
      cnt_nxt[i]  = eval_hit[i] ? cnt_upd : cnt[i];
    end
  end

`ifndef PRESSURE_ALARM_STICKY_EN
  logic unused_clr;
  assign unused_clr = ^alarmClr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      ch_reg  <= '0;
      smp_reg <= '0;
      abn_reg <= 1'b0;
      alarm   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      if (state == IDLE && |req) begin
        smp_reg <= pick_smp;
        ch_reg  <= pick_ch;
        rr_ptr  <= (pick_ch == CHW'(NUM_CH - 1)) ? '0 : pick_ch + 1'b1;
      end
      if (state == SAMPLE) abn_reg <= det_abn;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt[i] <= cnt_nxt[i];
`ifdef PRESSURE_ALARM_STICKY_EN
        // Set takes priority over a coincident clear.
        if (eval_hit[i] && cnt_nxt[i] == CW'(THRESH)) alarm[i] <= 1'b1;
        else if (alarmClr[i])                         alarm[i] <= 1'b0;
`else
        alarm[i] <= (cnt_nxt[i] == CW'(THRESH));
`endif
      end
    end
  end
endmodule

// File: tb/tb_pressure_scan_scheduler.sv
// Scoreboard bench for pressure_scan_scheduler; honours PRESSURE_ALARM_STICKY_EN.
module tb_pressure_scan_scheduler;
  import pressure_pkg::*;

  localparam int NC = 4;
  localparam int TH = 3;
  localparam logic [5:0] SA = 6'd3;   // flagged by the detector
  localparam logic [5:0] SN = 6'd30;  // normal

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] req;
  logic [NC*6-1:0] req_data;
  logic [NC-1:0] grant;
  logic          res_valid;
  logic [1:0]    res_ch;
  logic          res_abn;
  logic [NC-1:0] alarm;
  logic [NC-1:0] alarm_clr;
  logic          busy;

  always #5 clk = ~clk;

  pressure_scan_scheduler #(.NUM_CH(NC), .THRESH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .reqData(req_data), .grant(grant),
    .resValid(res_valid), .resCh(res_ch), .resAbn(res_abn), .alarm(alarm),
    .alarmClr(alarm_clr), .busy(busy)
  );

  logic [NC-1:0] flag;
  for (genvar g = 0; g < NC; g++) begin : g_ref
    pressureAbnormalityDetector u_ref (
      .pressureData(req_data[g*6 +: 6]), .pressureAbnormality(flag[g]));
  end

  int compared   = 0;
  int mismatched = 0;

  typedef struct { int ch; bit abn; } res_t;
  res_t exp_q[$];

  int          m_phase, m_ptr, m_ch;
  bit          m_abn;
  int          m_cnt [NC];
  bit [NC-1:0] m_alarm;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NC*6-1:0] fill(input logic [5:0] v);
    return {NC{v}};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_ch = 0; m_abn = 0; m_alarm = '0;
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    exp_q.delete();
  endtask

  // One clock: drive after the edge, check and advance the model mid-cycle.
  task automatic cycle(input logic [NC-1:0] r, input logic [NC*6-1:0] d,
                       input logic [NC-1:0] c);
    int k, cc;
    bit ev;
    logic [NC-1:0] eg;
    @(posedge clk); #1;
    req = r; req_data = d; alarm_clr = c;
    @(negedge clk);
    eg = '0; k = -1;
    if (m_phase == 0 && r != 0) begin
      for (int off = 0; off < NC; off++) begin
        cc = (m_ptr + off) % NC;
        if (k < 0 && r[cc]) k = cc;
      end
      eg[k] = 1'b1;
    end
    check("grant", int'(grant), int'(eg));
    check("busy", int'(busy), int'(m_phase != 0));
    check("resValid", int'(res_valid), int'(m_phase == 2));
    check("alarm", int'(alarm), int'(m_alarm));
    ev = (m_phase == 2);
    case (m_phase)
      0: if (k >= 0) begin
           exp_q.push_back('{k, flag[k]});
           m_ch = k; m_abn = flag[k]; m_ptr = (k + 1) % NC; m_phase = 1;
         end
      1: m_phase = 2;
      default: m_phase = 0;
    endcase
    if (ev) m_cnt[m_ch] = m_abn ? ((m_cnt[m_ch] + 1 > TH) ? TH : m_cnt[m_ch] + 1) : 0;
    for (int i = 0; i < NC; i++) begin
`ifdef PRESSURE_ALARM_STICKY_EN
      if (ev && i == m_ch && m_cnt[i] == TH) m_alarm[i] = 1'b1;
      else if (c[i])                         m_alarm[i] = 1'b0;
`else
      m_alarm[i] = (m_cnt[i] == TH);
`endif
    end
  endtask

  // Grant, SAMPLE, EVAL, then one idle cycle so the alarm update is visible.
  task automatic serve(input int ch, input logic [5:0] v, input logic clr_eval);
    logic [NC-1:0] r, c;
    r = '0; r[ch] = 1'b1;
    c = '0; c[ch] = clr_eval;
    cycle(r, fill(v), '0);
    cycle('0, fill(v), '0);
    cycle('0, fill(v), c);
    cycle('0, fill(v), '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, int'(grant), 0);
    check({tag, "_resValid"}, int'(res_valid), 0);
    check({tag, "_resCh"}, int'(res_ch), 0);
    check({tag, "_resAbn"}, int'(res_abn), 0);
    check({tag, "_alarm"}, int'(alarm), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resValid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("resCh", int'(res_ch), e.ch);
          check("resAbn", int'(res_abn), int'(e.abn));
        end
      end
    end
  end

  initial begin : stim
    logic [NC-1:0] r, c;
    logic [NC*6-1:0] d;
    rst_n = 1'b0; req = '0; req_data = '0; alarm_clr = '0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Single request on channel 2 with a normal sample.
    cycle(4'b0100, fill(SN), '0);
    check("single_grant", int'(grant), 4'b0100);
    cycle('0, fill(SN), '0);
    check("single_busy_t1", int'(busy), 1);
    cycle('0, fill(SN), '0);
    check("single_valid", int'(res_valid), 1);
    check("single_ch", int'(res_ch), 2);
    check("single_abn", int'(res_abn), 0);
    cycle('0, fill(SN), '0);

    // All channels held: round-robin order checked by the model.
    for (int i = 0; i < 18; i++) cycle(4'b1111, fill(SN), '0);
    for (int i = 0; i < 3; i++) cycle('0, fill(SN), '0);

    // Threshold on channel 1.
    serve(1, SA, 1'b0);
    serve(1, SA, 1'b0);
    check("ch1_after2", int'(alarm[1]), 0);
    serve(1, SA, 1'b0);
    check("ch1_after3", int'(alarm[1]), 1);
    serve(1, SN, 1'b0);
`ifdef PRESSURE_ALARM_STICKY_EN
    check("ch1_sticky_after_n", int'(alarm[1]), 1);
`else
    check("ch1_drop_after_n", int'(alarm[1]), 0);
`endif

    // Broken run on channel 2 never alarms.
    serve(2, SA, 1'b0); serve(2, SA, 1'b0); serve(2, SN, 1'b0);
    serve(2, SA, 1'b0); serve(2, SA, 1'b0);
    check("ch2_broken_run", int'(alarm[2]), 0);

    // Channel 0: clear coincident with the setting EVAL, then N, then a clear pulse.
    serve(0, SA, 1'b0); serve(0, SA, 1'b0); serve(0, SA, 1'b1);
    check("ch0_set_wins", int'(alarm[0]), 1);
    serve(0, SN, 1'b0);
`ifdef PRESSURE_ALARM_STICKY_EN
    check("ch0_sticky_n", int'(alarm[0]), 1);
    cycle('0, fill(SN), 4'b0001);
    cycle('0, fill(SN), '0);
    check("ch0_cleared", int'(alarm[0]), 0);
`else
    check("ch0_drop_n", int'(alarm[0]), 0);
    serve(0, SA, 1'b0); serve(0, SA, 1'b0); serve(0, SA, 1'b0);
    cycle('0, fill(SN), 4'b0001);
    cycle('0, fill(SN), '0);
    check("ch0_clr_ignored", int'(alarm[0]), 1);
`endif

    // Reset during SAMPLE.
    cycle(4'b0010, fill(SA), '0);
    @(posedge clk); #1;
    req = '0; rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    cycle(4'b0001, fill(SN), '0);
    check("post_reset_grant", int'(grant), 4'b0001);
    for (int i = 0; i < 3; i++) cycle('0, fill(SN), '0);

    // Randomized traffic.
    for (int i = 0; i < 900; i++) begin
      r = NC'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = '0;
      for (int j = 0; j < NC; j++)
        d[j*6 +: 6] = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7))
                                                  : 6'($urandom_range(0, 63));
      c = ($urandom_range(0, 5) == 0) ? NC'($urandom_range(0, 15)) : '0;
      cycle(r, d, c);
    end
    for (int i = 0; i < 4; i++) cycle('0, fill(SN), '0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
